// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, digit bounds and the load-path clamp.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  // Any non-decimal nibble is forced to 9 so the register never holds an illegal code.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle for the BCD up/down counter; master drives controls, slave owns the count.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 3
) ();

  logic                  enable;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count;
  logic                  saturation;
  logic                  wrap;

  modport master (
    output enable, up, load, load_value,
    input  count, saturation, wrap
  );

  modport slave (
    input  enable, up, load, load_value,
    output count, saturation, wrap
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register with load, single up/down step and bound flags.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_nxt;

  always_comb begin
    digit_nxt = digit;
    if (up) digit_nxt = (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
    else    digit_nxt = (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
  end

  // Register stage: reset > load > step > hold
  always_ff @(posedge clk) begin
    if (reset)        digit <= BCD_MIN;
    else if (load)    digit <= bcd_clamp(load_digit);
    else if (step_in) digit <= digit_nxt;
  end

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, saturate-or-wrap bounds and wrap pulse.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_updown_counter_if.slave   bus
);

  logic [DIGITS-1:0]   at_max;
  logic [DIGITS-1:0]   at_min;
  logic [DIGITS-1:0]   carry;
  logic [DIGITS-1:0]   step_in;
  logic [4*DIGITS-1:0] count_w;
  logic                bound;
  logic                bound_hit;
  logic                step_ok;
  logic                wrap_p1;

  // Digit i moves only when every lower digit sits at the bound in the current direction.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++)
      carry[i] = carry[i-1] & (bus.up ? at_max[i-1] : at_min[i-1]);
  end

  assign bound     = bus.up ? (&at_max) : (&at_min);
  assign bound_hit = bus.enable & bound;
  assign step_ok   = bus.enable & ~(SATURATE & bound_hit);
  assign step_in   = carry & {DIGITS{step_ok}};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .step_in    (step_in[g]),
      .up         (bus.up),
      .load       (bus.load),
      .load_digit (bus.load_value[4*g +: 4]),
      .digit      (count_w[4*g +: 4]),
      .at_max     (at_max[g]),
      .at_min     (at_min[g])
    );
  end

  // Wrap stage: one-cycle pulse after a step taken across the bound
  always_ff @(posedge clk) begin
    if (reset)         wrap_p1 <= 1'b0;
    else if (bus.load) wrap_p1 <= 1'b0;
    else               wrap_p1 <= bound_hit & ~SATURATE;
  end

  assign bus.count      = count_w;
  assign bus.saturation = bound;
  assign bus.wrap       = wrap_p1;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: saturating, wrapping and single-digit instances share one stimulus.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        up;
  logic        load;
  logic [11:0] load_value;

  int n_checks = 0;
  int n_fail   = 0;
  logic sat_wrap_seen;

  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(3)) if_sat ();
  bcd_updown_counter_if #(.DIGITS(3)) if_wrp ();
  bcd_updown_counter_if #(.DIGITS(1)) if_one ();

  assign if_sat.enable = enable;  assign if_sat.up = up;
  assign if_sat.load   = load;    assign if_sat.load_value = load_value;
  assign if_wrp.enable = enable;  assign if_wrp.up = up;
  assign if_wrp.load   = load;    assign if_wrp.load_value = load_value;
  assign if_one.enable = enable;  assign if_one.up = up;
  assign if_one.load   = load;    assign if_one.load_value = load_value[3:0];

  bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b1)) u_sat (.clk(clk), .reset(reset), .bus(if_sat.slave));
  bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b0)) u_wrp (.clk(clk), .reset(reset), .bus(if_wrp.slave));
  bcd_updown_counter #(.DIGITS(1), .SATURATE(1'b0)) u_one (.clk(clk), .reset(reset), .bus(if_one.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = 12'h000;
    tick();
    check("rst_cnt_sat", 32'(if_sat.count), 32'h000);
    check("rst_cnt_wrp", 32'(if_wrp.count), 32'h000);
    check("rst_wrap_wrp", 32'(if_wrp.wrap), 32'h0);
    check("rst_satlvl_up", 32'(if_sat.saturation), 32'h0);
    up = 1'b0; #1;
    check("rst_satlvl_dn", 32'(if_sat.saturation), 32'h1);
    check("rst_satlvl_one", 32'(if_one.saturation), 32'h1);

    // Count up 1000 times from zero
    reset = 1'b0; up = 1'b1; enable = 1'b1;
    sat_wrap_seen = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      sat_wrap_seen = sat_wrap_seen | if_sat.wrap;
      if (k == 1)    check("up_k1", 32'(if_sat.count), 32'h001);
      if (k == 10)   check("up_k10", 32'(if_sat.count), 32'h010);
      if (k == 109)  check("up_k109", 32'(if_sat.count), 32'h109);
      if (k == 999) begin
        check("up_k999_sat", 32'(if_sat.count), 32'h999);
        check("up_k999_wrp", 32'(if_wrp.count), 32'h999);
        check("up_k999_wrpw", 32'(if_wrp.wrap), 32'h0);
      end
    end
    check("up_k1000_sat", 32'(if_sat.count), 32'h999);
    check("up_k1000_lvl", 32'(if_sat.saturation), 32'h1);
    check("sat_never_wrap", 32'(sat_wrap_seen), 32'h0);
    check("up_k1000_wrp", 32'(if_wrp.count), 32'h000);
    check("up_k1000_wrpw", 32'(if_wrp.wrap), 32'h1);
    check("up_k1000_one", 32'(if_one.count), 32'h0);
    check("up_k1000_onew", 32'(if_one.wrap), 32'h1);
    enable = 1'b0; up = 1'b0; #1;
    check("lvl_999_dn", 32'(if_sat.saturation), 32'h0);
    up = 1'b1; #1;
    check("lvl_999_up_noen", 32'(if_sat.saturation), 32'h1);

    // Load 0x100 with enable: load wins, then one borrow ripple
    load = 1'b1; load_value = 12'h100; up = 1'b0; enable = 1'b1;
    tick();
    check("ld100", 32'(if_sat.count), 32'h100);
    check("ld100_wrpw", 32'(if_wrp.wrap), 32'h0);
    load = 1'b0;
    tick();
    check("borrow_099", 32'(if_sat.count), 32'h099);

    // Wrap from 0x998 upward
    load = 1'b1; load_value = 12'h998; enable = 1'b0; up = 1'b1;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    check("w998_a_cnt", 32'(if_wrp.count), 32'h999);
    check("w998_a_w", 32'(if_wrp.wrap), 32'h0);
    tick();
    check("w998_b_cnt", 32'(if_wrp.count), 32'h000);
    check("w998_b_w", 32'(if_wrp.wrap), 32'h1);
    check("s998_b_cnt", 32'(if_sat.count), 32'h999);
    tick();
    check("w998_c_cnt", 32'(if_wrp.count), 32'h001);
    check("w998_c_w", 32'(if_wrp.wrap), 32'h0);
    check("s998_c_cnt", 32'(if_sat.count), 32'h999);
    check("s998_c_w", 32'(if_sat.wrap), 32'h0);

    // Downward across zero
    load = 1'b1; load_value = 12'h000; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1; up = 1'b0;
    tick();
    check("dn0_wrp_cnt", 32'(if_wrp.count), 32'h999);
    check("dn0_wrp_w", 32'(if_wrp.wrap), 32'h1);
    check("dn0_sat_cnt", 32'(if_sat.count), 32'h000);
    check("dn0_sat_w", 32'(if_sat.wrap), 32'h0);
    check("dn0_sat_lvl", 32'(if_sat.saturation), 32'h1);
    enable = 1'b0;
    tick();
    check("dn0_wrp_w_end", 32'(if_wrp.wrap), 32'h0);
    check("dn0_hold", 32'(if_wrp.count), 32'h999);

    // Load with clamping, enable ignored
    load = 1'b1; load_value = 12'hA3F; enable = 1'b1; up = 1'b1;
    tick();
    check("clamp_sat", 32'(if_sat.count), 32'h939);
    check("clamp_wrp", 32'(if_wrp.count), 32'h939);
    check("clamp_one", 32'(if_one.count), 32'h9);

    // Single digit: alternating direction gives back-to-back wraps
    load = 1'b0; enable = 1'b1; up = 1'b1;
    tick();
    check("one_a_cnt", 32'(if_one.count), 32'h0);
    check("one_a_w", 32'(if_one.wrap), 32'h1);
    up = 1'b0;
    tick();
    check("one_b_cnt", 32'(if_one.count), 32'h9);
    check("one_b_w", 32'(if_one.wrap), 32'h1);
    up = 1'b1;
    tick();
    check("one_c_cnt", 32'(if_one.count), 32'h0);
    check("one_c_w", 32'(if_one.wrap), 32'h1);
    enable = 1'b0;
    tick();
    check("one_d_w", 32'(if_one.wrap), 32'h0);

    // Reset beats load and enable
    load = 1'b1; load_value = 12'h457;
    tick();
    check("ld457", 32'(if_sat.count), 32'h457);
    reset = 1'b1; load_value = 12'h123; enable = 1'b1;
    tick();
    check("rst_over_ld", 32'(if_sat.count), 32'h000);
    check("rst_over_ld_w", 32'(if_wrp.wrap), 32'h0);
    reset = 1'b0; enable = 1'b0; load_value = 12'h999;
    tick();
    check("ld999", 32'(if_wrp.count), 32'h999);
    load = 1'b0; reset = 1'b1; enable = 1'b1; up = 1'b1;
    tick();
    check("rst_pend_cnt", 32'(if_wrp.count), 32'h000);
    check("rst_pend_w", 32'(if_wrp.wrap), 32'h0);
    reset = 1'b0; enable = 1'b0;
    #1;
    check("rst_lvl_up", 32'(if_wrp.saturation), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
